// File: rtl/dmem_map_pkg.sv
// rtl/dmem_map_pkg.sv - address map, status layout and transmitter states for dmem_responder
// Purpose: constants shared by the data-memory responder and its UART sub-module.
// Ports: none (package).
package dmem_map_pkg;

  // MMIO window is the top 64K words of the address space.
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

  // Word offsets inside the MMIO window.
  localparam logic [15:0] OFF_CYCLE     = 16'd0;
  localparam logic [15:0] OFF_LED       = 16'd1;
  localparam logic [15:0] OFF_UART_DATA = 16'd2;
  localparam logic [15:0] OFF_STATUS    = 16'd2;
  localparam logic [15:0] OFF_OVF_CLR   = 16'd3;

  // Status register bit positions; count occupies [ST_COUNT_LSB +: 4].
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_BUSY      = 3;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit FIFO, sticky overflow flag and 8N1 serialiser
// Purpose: buffers bytes pushed by the MMIO decode and shifts them out LSB first.
// Ports: clock, reset (async active-low), i_push/i_byte (enqueue strobe + byte),
//        i_ovf_clr (clear sticky overflow), o_status (status byte), o_uart_tx (line).
module uart_tx_fifo
  import dmem_map_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_push,
  input  logic [7:0] i_byte,
  input  logic       i_ovf_clr,
  output logic [7:0] o_status,
  output logic       o_uart_tx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  tx_state_e     r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push_ok;

  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  // The FSM takes the head byte whenever it is idle and something is queued.
  assign w_pop     = (r_state == TX_IDLE) && !w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = i_push && (!w_full || w_pop);

  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_byte;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push_ok && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push_ok && w_pop) r_count <= r_count - CW'(1);
      if (i_ovf_clr)                   r_ovf <= 1'b0;
      else if (i_push && !w_push_ok)   r_ovf <= 1'b1;
    end
  end

  // r_tx is registered so the line changes on the edge that enters each bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= TX_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_baud  <= '0;
            r_tx    <= 1'b0;
            r_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_tx    <= r_shift[0];
            r_state <= TX_DATA;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        TX_DATA: begin
          if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= TX_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        TX_STOP: begin
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_state <= TX_IDLE;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  always_comb begin
    o_status                        = 8'd0;
    o_status[ST_FULL]               = w_full;
    o_status[ST_EMPTY]              = w_empty;
    o_status[ST_OVF]                = r_ovf;
    o_status[ST_BUSY]               = (r_state != TX_IDLE);
    o_status[ST_COUNT_LSB +: 4]     = 4'(r_count);
  end

  assign o_uart_tx = r_tx;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data RAM plus MMIO window (cycle counter, LEDs, UART) for the M stage
// Purpose: answers the processor data port with zero-latency reads and edge-timed writes.
// Ports: clock, reset (async active-low), address_dmem/data/wren (processor request),
//        q_dmem (combinational read data), leds (LED register), uart_tx (serial line).
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter int RAM_DEPTH  = 4096,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [15:0] leds,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_DEPTH);

  logic [31:0] r_ram [RAM_DEPTH];
  logic [31:0] r_cycle;
  logic [15:0] r_leds;

  logic          w_is_mmio;
  logic [15:0]   w_off;
  logic [AW-1:0] w_ram_idx;
  logic [7:0]    w_status;
  logic          w_push;
  logic          w_ovf_clr;

  assign w_is_mmio = (address_dmem[31:16] == MMIO_BASE[31:16]);
  assign w_off     = address_dmem[15:0];
  // Upper address bits are dropped, so RAM aliases modulo RAM_DEPTH.
  assign w_ram_idx = address_dmem[AW-1:0];
  assign w_push    = wren && w_is_mmio && (w_off == OFF_UART_DATA);
  assign w_ovf_clr = wren && w_is_mmio && (w_off == OFF_OVF_CLR);

  // RAM contents survive reset.
  always_ff @(posedge clock) begin
    if (wren && !w_is_mmio) r_ram[w_ram_idx] <= data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle <= 32'd0;
      r_leds  <= 16'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (wren && w_is_mmio && (w_off == OFF_LED)) r_leds <= data[15:0];
    end
  end

  always_comb begin
    q_dmem = 32'd0;
    if (w_is_mmio) begin
      case (w_off)
        OFF_CYCLE:  q_dmem = r_cycle;
        OFF_LED:    q_dmem = {16'd0, r_leds};
        OFF_STATUS: q_dmem = {24'd0, w_status};
        default:    q_dmem = 32'd0;
      endcase
    end else begin
      q_dmem = r_ram[w_ram_idx];
    end
  end

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BAUD_DIV   (BAUD_DIV)
  ) u_uart (
    .clock     (clock),
    .reset     (reset),
    .i_push    (w_push),
    .i_byte    (data[7:0]),
    .i_ovf_clr (w_ovf_clr),
    .o_status  (w_status),
    .o_uart_tx (uart_tx)
  );

  assign leds = r_leds;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int RAM_DEPTH  = 4096;
  localparam int FIFO_DEPTH = 8;
  localparam int BAUD_DIV   = 16;
  localparam int FRAME      = 10 * BAUD_DIV;
  localparam logic [31:0] MMIO = 32'hFFFF_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_dmem = 32'd0;
  logic [31:0] data = 32'd0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic [15:0] leds;
  logic        uart_tx;

  dmem_responder #(
    .RAM_DEPTH  (RAM_DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BAUD_DIV   (BAUD_DIV)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .leds         (leds),
    .uart_tx      (uart_tx)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: memory map behaviour and a frame-timer view of the transmitter.
  logic [31:0] m_ram [int];
  logic [31:0] m_cyc;
  logic [15:0] m_leds;
  logic        m_ovf;
  logic [7:0]  m_q [$];
  int          m_rem;
  logic [7:0]  m_byte;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    bit          chk_q;
    logic [31:0] exp_q;
    logic [15:0] exp_leds;
  } vec_t;
  vec_t tv [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic m_line();
    int k;
    if (m_rem == 0) return 1'b1;
    k = (FRAME - m_rem) / BAUD_DIV;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] v;
    int s;
    s = m_q.size();
    v = 32'd0;
    v[0]   = (s == FIFO_DEPTH);
    v[1]   = (s == 0);
    v[2]   = m_ovf;
    v[3]   = (m_rem != 0);
    v[7:4] = 4'(s);
    return v;
  endfunction

  task automatic m_read(input logic [31:0] a, output bit known, output logic [31:0] v);
    int i;
    known = 1'b1;
    v = 32'd0;
    if (a[31:16] == 16'hFFFF) begin
      case (a[15:0])
        16'd0:   v = m_cyc;
        16'd1:   v = {16'd0, m_leds};
        16'd2:   v = m_status();
        default: v = 32'd0;
      endcase
    end else begin
      i = int'(a % RAM_DEPTH);
      if (m_ram.exists(i)) v = m_ram[i];
      else known = 1'b0;
    end
  endtask

  task automatic m_reset();
    m_cyc  = 32'd0;
    m_leds = 16'd0;
    m_ovf  = 1'b0;
    m_q.delete();
    m_rem  = 0;
  endtask

  task automatic m_edge();
    int n;
    bit pop, push;
    n = m_q.size();
    pop = (m_rem == 0) && (n > 0);
    push = 1'b0;
    m_cyc = m_cyc + 32'd1;
    if (wren) begin
      if (address_dmem[31:16] == 16'hFFFF) begin
        case (address_dmem[15:0])
          16'd1: m_leds = data[15:0];
          16'd2: push = 1'b1;
          16'd3: m_ovf = 1'b0;
          default: ;
        endcase
      end else begin
        m_ram[int'(address_dmem % RAM_DEPTH)] = data;
      end
    end
    if (pop) begin
      m_byte = m_q.pop_front();
      m_rem = FRAME;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    if (push) begin
      if (n < FIFO_DEPTH || pop) m_q.push_back(data[7:0]);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
    address_dmem = a;
    data = d;
    wren = w;
  endtask

  // Checks combinational outputs against the model, then advances one clock.
  task automatic tick(input string tag);
    bit known;
    logic [31:0] v;
    #1;
    m_read(address_dmem, known, v);
    if (known) chk({tag, " q_dmem"}, q_dmem, v);
    chk({tag, " uart_tx"}, 32'(uart_tx), 32'(m_line()));
    chk({tag, " leds"}, 32'(leds), 32'(m_leds));
    @(posedge clock);
    m_edge();
    #1;
  endtask

  task automatic do_reset();
    drive(32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic add(input logic [31:0] a, input logic [31:0] d, input logic w,
                     input bit cq, input logic [31:0] eq, input logic [15:0] el);
    vec_t v;
    v.addr = a; v.wdata = d; v.wr = w; v.chk_q = cq; v.exp_q = eq; v.exp_leds = el;
    tv.push_back(v);
  endtask

  initial begin
    logic [9:0]  fr;
    logic [31:0] ra;
    int          op;

    m_reset();
    // Fixed vectors from a clean reset.
    add(32'd5,                   32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0,          16'h0000);
    add(32'd5,                   32'd0,         1'b0, 1'b1, 32'hDEAD_BEEF,  16'h0000);
    add(32'd5 + RAM_DEPTH,       32'd0,         1'b0, 1'b1, 32'hDEAD_BEEF,  16'h0000);
    add(32'd5 + 3 * RAM_DEPTH,   32'd0,         1'b0, 1'b1, 32'hDEAD_BEEF,  16'h0000);
    add(32'hFFFE_FFFF,           32'hCAFE_F00D, 1'b1, 1'b0, 32'd0,          16'h0000);
    add(32'h0000_0FFF,           32'd0,         1'b0, 1'b1, 32'hCAFE_F00D,  16'h0000);
    add(32'd7 + RAM_DEPTH,       32'h1111_2222, 1'b1, 1'b0, 32'd0,          16'h0000);
    add(32'd7,                   32'd0,         1'b0, 1'b1, 32'h1111_2222,  16'h0000);
    add(MMIO + 32'd2,            32'd0,         1'b0, 1'b1, 32'h0000_0002,  16'h0000);
    add(MMIO + 32'd1,            32'h1234_ABCD, 1'b1, 1'b1, 32'h0000_0000,  16'h0000);
    add(MMIO + 32'd1,            32'd0,         1'b0, 1'b1, 32'h0000_ABCD,  16'hABCD);
    add(MMIO + 32'd3,            32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000,  16'hABCD);
    add(MMIO + 32'h10,           32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000,  16'hABCD);
    add(MMIO + 32'd1,            32'd0,         1'b0, 1'b1, 32'h0000_ABCD,  16'hABCD);
    add(MMIO + 32'd3,            32'd0,         1'b0, 1'b1, 32'h0000_0000,  16'hABCD);
    add(MMIO + 32'd2,            32'd0,         1'b0, 1'b1, 32'h0000_0002,  16'hABCD);

    do_reset();
    #1;
    chk("reset uart_tx", 32'(uart_tx), 32'd1);
    chk("reset leds", 32'(leds), 32'd0);
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].addr, tv[i].wdata, tv[i].wr);
      #1;
      if (tv[i].chk_q) chk($sformatf("vec%0d q_dmem", i), q_dmem, tv[i].exp_q);
      chk($sformatf("vec%0d leds", i), 32'(leds), 32'(tv[i].exp_leds));
      tick($sformatf("vec%0d", i));
    end

    // Cycle counter counts edges since reset release; writes to it are ignored.
    do_reset();
    drive(MMIO, 32'd0, 1'b0);
    repeat (100) tick("cnt");
    #1;
    chk("counter at 100", q_dmem, 32'd100);
    drive(MMIO, 32'h0000_0000, 1'b1);
    tick("cnt wr");
    drive(MMIO, 32'd0, 1'b0);
    #1;
    chk("counter write ignored", q_dmem, 32'd101);

    // Single byte 0x55: frame shape, busy and empty flags.
    do_reset();
    drive(MMIO + 32'd2, 32'h0000_0055, 1'b1);
    tick("t4 push");
    drive(MMIO + 32'd2, 32'd0, 1'b0);
    #1;
    chk("t4 idle after push", 32'(uart_tx), 32'd1);
    chk("t4 status queued", q_dmem, 32'h0000_0010);
    tick("t4 pop");
    fr = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BAUD_DIV; c++) begin
        #1;
        chk($sformatf("t4 bit%0d clk%0d", b, c), 32'(uart_tx), 32'(fr[b]));
        if (b == 5 && c == 0) chk("t4 status busy", q_dmem, 32'h0000_000A);
        tick("t4 frame");
      end
    end
    #1;
    chk("t4 status done", q_dmem, 32'h0000_0002);
    chk("t4 line idle", 32'(uart_tx), 32'd1);

    // Ten back-to-back pushes: one in flight, eight queued, one rejected.
    for (int i = 0; i < 10; i++) begin
      drive(MMIO + 32'd2, 32'hA0 + i, 1'b1);
      tick("t5 push");
    end
    drive(MMIO + 32'd2, 32'd0, 1'b0);
    #1;
    chk("t5 status full+ovf", q_dmem, 32'h0000_008D);
    drive(MMIO + 32'd3, 32'd0, 1'b1);
    tick("t5 clr");
    drive(MMIO + 32'd2, 32'd0, 1'b0);
    #1;
    chk("t5 status ovf cleared", q_dmem, 32'h0000_0089);
    repeat (9 * (FRAME + 1) + 4) tick("t5 drain");
    #1;
    chk("t5 status drained", q_dmem, 32'h0000_0002);

    // Reset in the middle of a data bit of 0x00 forces the line high at once.
    drive(MMIO + 32'd1, 32'h0000_5A5A, 1'b1);
    tick("t6 led");
    drive(MMIO + 32'd2, 32'h0000_0000, 1'b1);
    tick("t6 push");
    drive(MMIO + 32'd2, 32'd0, 1'b0);
    repeat (60) tick("t6 run");
    chk("t6 line low mid-data", 32'(uart_tx), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("t6 async line high", 32'(uart_tx), 32'd1);
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("t6 status after reset", q_dmem, 32'h0000_0002);
    chk("t6 leds after reset", 32'(leds), 32'd0);
    drive(32'd5, 32'd0, 1'b0);
    #1;
    chk("t6 ram retained", q_dmem, 32'hDEAD_BEEF);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      op = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 0) ra = 32'($urandom_range(0, 15)) + RAM_DEPTH * $urandom_range(0, 7);
      else ra = 32'hFFFE_F000 + 32'($urandom_range(0, 15));
      case (op)
        0, 1, 2: drive(ra, $urandom, 1'b1);
        3, 4, 5: drive(ra, $urandom, 1'b0);
        6:       drive(MMIO + 32'd1, $urandom, 1'b1);
        7:       drive(MMIO + 32'd2, $urandom, ($urandom_range(0, 3) == 0));
        8:       drive(MMIO + 32'd3, $urandom, 1'b1);
        9:       drive(MMIO + 32'($urandom_range(0, 5)), $urandom, 1'b0);
        10:      drive(MMIO + 32'($urandom_range(0, 1) == 0 ? 0 : 32'h1234), $urandom, 1'b1);
        default: drive(MMIO + 32'd2, $urandom, 1'b0);
      endcase
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
